seq_divider_32by16: RTL

- Iterative restoring divider; the inverse of the team's 16x16 array multiplier.
- Takes a 32-bit dividend (a product-width value) and a 16-bit divisor; returns a 16-bit quotient and 16-bit remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath and uses a start/busy/done handshake.

---
 rtl/arith_pkg.sv | 15 +
 rtl/div_step.sv | 33 +++
 rtl/seq_divider_32by16.sv | 138 +++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: divider state encoding,
// iteration count and the fixed result returned on overflow.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          DIV_ITER = 16;
  localparam logic [15:0] QUOT_OVF = 16'hFFFF;
  localparam logic [15:0] REM_OVF  = 16'h0000;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_div_ext;
  logic           w_unused_msb;

  // The partial remainder stays below the divisor, so its top bit is
  // always clear and drops out of the shift.
  assign w_unused_msb = i_rem[WIDTH];

  // Trial subtract on WIDTH+1 bits, keep the difference when it fits.
  always_comb begin
    w_trial   = {i_rem[WIDTH-1:0], i_bit};
    w_div_ext = {1'b0, i_div};
    o_qbit    = 1'b0;
    o_rem     = w_trial;
    if (w_trial >= w_div_ext) begin
      o_qbit = 1'b1;
      o_rem  = w_trial - w_div_ext;
    end
  end

endmodule

// File: rtl/seq_divider_32by16.sv
// Iterative restoring 32/16 divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SELFCHECK_EN to add the oCheckErr result checker.
module seq_divider_32by16
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic [2*WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0]   iDivisor,
  output logic               oBusy,
  output logic               oDone,
  output logic               oOverflow,
  output logic [WIDTH-1:0]   oQuotient,
`ifdef SEQ_DIVIDER_SELFCHECK_EN
  output logic               oCheckErr,
`endif
  output logic [WIDTH-1:0]   oRemainder
);

  state_t             r_state;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_s;
  logic [WIDTH-1:0]   r_d;
  logic [4:0]         r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_remo;

  logic [WIDTH:0]     w_rem;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_s_next;
  logic               w_hi_ovf;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_s[WIDTH-1]),
    .i_div  (r_d),
    .o_rem  (w_rem),
    .o_qbit (w_qbit)
  );

  assign w_s_next = {r_s[WIDTH-2:0], w_qbit};
  assign w_hi_ovf = iDividend[2*WIDTH-1:WIDTH] >= iDivisor;

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_s     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            r_busy <= 1'b1;
            if (w_hi_ovf) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_ovf   <= 1'b1;
              r_quot  <= QUOT_OVF;
              r_remo  <= REM_OVF;
            end else begin
              r_state <= ST_RUN;
              r_ovf   <= 1'b0;
              r_rem   <= {1'b0, iDividend[2*WIDTH-1:WIDTH]};
              r_s     <= iDividend[WIDTH-1:0];
              r_d     <= iDivisor;
              r_cnt   <= '0;
            end
          end
        end
        ST_RUN: begin
          r_rem <= w_rem;
          r_s   <= w_s_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(DIV_ITER - 1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_quot  <= w_s_next;
            r_remo  <= w_rem[WIDTH-1:0];
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_DIVIDER_SELFCHECK_EN
  logic [2*WIDTH-1:0] r_dvd;
  logic               r_chk;
  logic [2*WIDTH-1:0] w_recon;

  assign w_recon = ({{WIDTH{1'b0}}, r_quot} * {{WIDTH{1'b0}}, r_d})
                 + {{WIDTH{1'b0}}, r_remo};

  // Capture the dividend and flag any Q*D+R mismatch until reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_dvd <= '0;
      r_chk <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && iStart && !w_hi_ovf)
        r_dvd <= iDividend;
      if (r_state == ST_DONE && !r_ovf && w_recon != r_dvd)
        r_chk <= 1'b1;
    end
  end

  assign oCheckErr = r_chk;
`endif

  assign oBusy      = r_busy;
  assign oDone      = r_done;
  assign oOverflow  = r_ovf;
  assign oQuotient  = r_quot;
  assign oRemainder = r_remo;

endmodule
